// File: rtl/multiword_ks_add.sv
// Multiword adder: adds two W-bit operands one 16-bit chunk per cycle, rippling the
// carry through a register, with valid/ready handshakes on both sides.
module multiword_ks_add #(
    parameter int unsigned WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [16*WORDS-1:0] a,
    input  logic [16*WORDS-1:0] b,
    input  logic                cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [16*WORDS-1:0] sum,
    output logic                cout
);

    localparam int unsigned W    = 16 * WORDS;
    localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StAdd,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic [IdxW-1:0] idx_q, idx_d;

    logic [IdxW+3:0] off;
    logic [16:0]     chunk;
    logic            last;

    always_comb begin
        off   = {idx_q, 4'h0};
        chunk = {1'b0, a_q[off +: 16]} + {1'b0, b_q[off +: 16]} + {16'h0000, carry_q};
        last  = (idx_q == IdxW'(WORDS - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = StAdd;
                end
            end
            StAdd: begin
                sum_d[off +: 16] = chunk[15:0];
                carry_d          = chunk[16];
                idx_d            = idx_q + 1'b1;
                if (last) begin
                    cout_d  = chunk[16];
                    idx_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                // Consuming edge only returns to idle; acceptance waits one cycle.
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule
